ram_access_bridge: RTL and testbench

// - Bus-side front end for the single-port word RAM: valid/ready request channel in, response channel out.
// - Converts byte-enabled stores into whole-word RAM writes, merging via read-modify-write against the RAM's combinational read port.
// - Flags misaligned or out-of-range accesses with an error response; such requests never touch the RAM.
// - Sits between the core/bus interconnect and the RAM; drives the RAM's we/addr/data inputs, consumes its data output.

---
 rtl/ram_access_bridge.sv | 173 +++++++++++++++++
 tb/tb_ram_access_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_bridge.sv
// Bus-side front end for a single-port word RAM: valid/ready requests in, response channel out.
// Latency: request accepted at edge N, RAM access in cycle N+1, rsp_valid_o asserted from cycle N+2.
// Backpressure: one request in flight; req_ready_o stays low from accept until the response is taken.
//
// Optional feature macro: RAM_BRIDGE_RMW_EN
//   defined   -> partial byte-enable writes are merged with the current RAM word (read-modify-write)
//   undefined -> partial byte-enable writes are rejected with rsp_err_o; the merge datapath is absent
//
// Ports:
//   clk_i, rst_ni                     clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o           request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_be_i             request payload (byte address, byte enables)
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o, rsp_err_o            response payload (rdata is 0 for writes and errors)
//   ram_we_o, ram_addr_o, ram_wdata_o RAM write port / address
//   ram_rdata_i                       RAM combinational read data
module ram_access_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_NUM = 4096
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [DW/8-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            ram_we_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic [DW-1:0]   ram_wdata_o,
    input  logic [DW-1:0]   ram_rdata_i
);

    localparam int BW = DW / 8;
    localparam logic [AW-3:0] MEM_WORDS = (AW-2)'(MEM_NUM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Captured request
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic            accept;

    // Response registers
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    // Last word driven to the RAM, so ram_wdata_o holds outside write cycles
    logic [DW-1:0]   ram_wdata_q;

    logic            be_full;
    logic            be_none;
    logic            be_err;
    logic            acc_err;
    logic            do_write;
    logic [DW-1:0]   wr_word;

    assign be_full = &be_q;
    assign be_none = ~|be_q;

`ifdef RAM_BRIDGE_RMW_EN
    logic [DW-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < BW; i++) begin
            mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    // Full-word enables reduce to wdata_q through the same merge.
    assign wr_word = (ram_rdata_i & ~mask) | (wdata_q & mask);
    assign be_err  = 1'b0;
`else
    assign wr_word = wdata_q;
    assign be_err  = we_q && !be_full && !be_none;
`endif

    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[AW-1:2] >= MEM_WORDS) || be_err;
    // An all-zero byte enable is a legal no-op write: no RAM cycle, no error.
    assign do_write = (state_q == ACCESS) && we_q && !acc_err && !be_none;

    // The RAM sees the captured address throughout ACCESS and keeps it afterwards.
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = do_write ? wr_word : ram_wdata_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = 1'b0;
        ram_we_o    = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we_o    = do_write;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (!we_q && !acc_err) ? ram_rdata_i : '0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ram_wdata_q <= '0;
        end else if (do_write) begin
            ram_wdata_q <= wr_word;
        end
    end

endmodule

// File: tb/tb_ram_access_bridge.sv
module tb_ram_access_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

`ifdef RAM_BRIDGE_RMW_EN
    localparam logic [31:0] EXP_20    = 32'h1122AA44;
    localparam logic        EXP_P_ERR = 1'b0;
`else
    localparam logic [31:0] EXP_20    = 32'h11223344;
    localparam logic        EXP_P_ERR = 1'b1;
`endif

    logic [31:0] mem [4096];

    always #5 clk_i = ~clk_i;

    assign ram_rdata_i = mem[ram_addr_o[13:2]];

    always @(posedge clk_i) begin
        if (ram_we_o) begin
            mem[ram_addr_o[13:2]] <= ram_wdata_o;
            we_cnt <= we_cnt + 1;
        end
    end

    ram_access_bridge #(.AW(32), .DW(32), .MEM_NUM(4096)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    // Presents a request at a falling edge and returns at the falling edge of the
    // ACCESS cycle, with req_valid_i dropped.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL accept_timeout addr=%h: req_ready_o never rose within 50 cycles", a);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // Full transaction; lat counts cycles from the accept cycle to the first cycle with rsp_valid_o.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
        issue(we, a, d, be);
        lat = 1;
        while (!rsp_valid_o && lat < 50) begin
            @(negedge clk_i);
            lat++;
        end
        checks++;
        if (lat >= 50) begin
            failures++;
            $display("FAIL rsp_timeout addr=%h: rsp_valid_o never rose within 50 cycles", a);
        end
        rd = rsp_rdata_o;
        er = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        int          wc;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata_o); end
        checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err_o); end
        checks++; if (ram_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", ram_we_o); end
        checks++; if (ram_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", ram_addr_o); end
        checks++; if (ram_wdata_o !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", ram_wdata_o); end
        rst_ni = 1'b1;

        // Reset in the middle of a write's ACCESS cycle: the RAM write must be cancelled.
        wc = we_cnt;
        issue(1'b1, 32'h30, 32'h55AA55AA, 4'hF);
        checks++; if (ram_we_o !== 1'b1) begin failures++; $display("FAIL access_we got=%b exp=1", ram_we_o); end
        #1 rst_ni = 1'b0;
        #1;
        checks++; if (ram_we_o !== 1'b0) begin failures++; $display("FAIL midacc_we got=%b exp=0", ram_we_o); end
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL midacc_ready got=%b exp=1", req_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        checks++; if (mem[12] !== 32'h0 || we_cnt != wc) begin failures++; $display("FAIL midacc_nowrite mem=%h writes=%0d exp mem=0 writes=%0d", mem[12], we_cnt, wc); end

        // Reset while a response is pending: it is discarded immediately.
        issue(1'b0, 32'h30, 32'h0, 4'hF);
        @(negedge clk_i);
        checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL resp_valid got=%b exp=1", rsp_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midresp_valid got=%b exp=0", rsp_valid_o); end
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL midresp_ready got=%b exp=1", req_ready_o); end
        checks++; if (ram_we_o !== 1'b0) begin failures++; $display("FAIL midresp_we got=%b exp=0", ram_we_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd = '0; er = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL wr_rsp err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        checks++; if (lat != 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[4]); end
        do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
        checks++; if (lat != 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_partial_write;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wc;
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h20, 32'h0000AA00, 4'b0010, rd, er, lat);
        checks++; if (er !== EXP_P_ERR) begin failures++; $display("FAIL partial_err got=%b exp=%b", er, EXP_P_ERR); end
        do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== EXP_20 || er !== 1'b0) begin failures++; $display("FAIL partial_read got=%h err=%b exp=%h err=0", rd, er, EXP_20); end
        // Zero byte enables: no RAM cycle, no error.
        wc = we_cnt;
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || we_cnt != wc) begin failures++; $display("FAIL be0 err=%b writes=%0d exp err=0 writes=%0d", er, we_cnt, wc); end
        checks++; if (mem[8] !== EXP_20) begin failures++; $display("FAIL be0_mem got=%h exp=%h", mem[8], EXP_20); end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wc;
        wc = we_cnt;
        do_req(1'b0, 32'h22, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misalign err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_req(1'b0, 32'h4000, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_read err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_req(1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_write err=%b exp=1", er); end
        do_req(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misalign_write err=%b exp=1", er); end
        checks++; if (we_cnt != wc || mem[0] !== 32'h0 || mem[4] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL err_nowrite writes=%0d mem0=%h mem4=%h exp writes=%0d mem0=0 mem4=deadbeef", we_cnt, mem[0], mem[4], wc);
        end
        // Last legal word is in range.
        do_req(1'b1, 32'h3FFC, 32'h0BADF00D, 4'hF, rd, er, lat);
        do_req(1'b0, 32'h3FFC, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0BADF00D) begin failures++; $display("FAIL last_word err=%b rdata=%h exp err=0 rdata=0badf00d", er, rd); end
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk_i);
        // Next request pending while the response is stalled.
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h20;
        req_be_i    = 4'hF;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_c%0d valid=%b rdata=%h err=%b ready=%b exp valid=1 rdata=deadbeef err=0 ready=0",
                         c, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
            end
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
            failures++; $display("FAIL release ready=%b valid=%b rdata=%h exp ready=1 valid=0 rdata=0", req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL next_accept ready=%b exp=0", req_ready_o); end
        @(negedge clk_i);
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== EXP_20) begin
            failures++; $display("FAIL next_rsp valid=%b rdata=%h exp valid=1 rdata=%h", rsp_valid_o, rsp_rdata_o, EXP_20);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h0;
        req_wdata_i = 32'h0;
        req_be_i    = 4'h0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_errors();
        test_back_to_back();
        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
